// File: rtl/coord_to_index_pkg.sv
// Shared grid constants and encoder state type.
// Also used by the index decoder and the triangle-area blocks.
package coord_to_index_pkg;

  localparam int GRID_W  = 600;
  localparam int GRID_H  = 600;
  localparam int COORD_W = 11;
  localparam int INDEX_W = 33;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/coord_to_index_mult_shift_add.sv
// Iterative shift-add multiply of an operand by a fixed multiplicand.
// One operand bit per clock, LSB first; fixed A_W-cycle latency.
module mult_shift_add
  import coord_to_index_pkg::*;
#(
  parameter int MCAND = GRID_W,
  parameter int A_W   = COORD_W,
  parameter int P_W   = INDEX_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [A_W-1:0] a,
  output logic           busy,
  output logic           done,
  output logic [P_W-1:0] product
);

  localparam int CNT_W = $clog2(A_W + 1);

  logic [A_W-1:0]   a_q, a_d;
  logic [P_W-1:0]   m_q, m_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    a_d    = a_q;
    m_d    = m_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done   = 1'b0;
    if (start) begin
      a_d    = a;
      m_d    = P_W'(MCAND);
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // m_q tracks MCAND << cnt, a_q[0] is operand bit cnt
      if (a_q[0]) acc_d = acc_q + m_q;
      a_d   = a_q >> 1;
      m_d   = m_q << 1;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(A_W - 1)) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      m_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      m_q    <= m_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // Final sum is presented in the same cycle as done
  assign busy    = busy_q;
  assign product = acc_d;

endmodule

// File: rtl/coord_to_index.sv
// Grid point (x row, y column) to linear index x*GRID_W + y.
// Valid/ready on both sides; fixed-latency shift-add multiply.
module coord_to_index
  import coord_to_index_pkg::*;
#(
  parameter int GRID_W  = coord_to_index_pkg::GRID_W,
  parameter int GRID_H  = coord_to_index_pkg::GRID_H,
  parameter int COORD_W = coord_to_index_pkg::COORD_W,
  parameter int INDEX_W = coord_to_index_pkg::INDEX_W
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INDEX_W-1:0] out_index,
  output logic               out_err
);

  state_e state_q, state_d;

  logic [COORD_W-1:0] y_q, y_d;
  logic               bad_q, bad_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic               err_q, err_d;

  logic               in_range;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [INDEX_W-1:0] mul_prod;

  assign in_range = (32'(in_x) < 32'(GRID_H)) &&
                    (32'(in_y) < 32'(GRID_W));

  mult_shift_add #(
    .MCAND (GRID_W),
    .A_W   (COORD_W),
    .P_W   (INDEX_W)
  ) u_mul (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .start   (mul_start),
    .a       (in_x),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    bad_d     = bad_q;
    idx_d     = idx_q;
    err_d     = err_q;
    mul_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && !mul_busy) begin
          y_d       = in_y;
          bad_d     = !in_range;
          mul_start = in_range;
          state_d   = ST_MUL;
        end
      end
      ST_MUL: begin
        // Rejected points spend one cycle here, giving a 1-cycle result
        if (bad_q) begin
          idx_d   = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (mul_done) begin
          idx_d   = mul_prod + INDEX_W'(y_q);
          err_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      bad_q   <= bad_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !mul_busy;
  assign out_valid = (state_q == ST_DONE);
  assign out_index = idx_q;
  assign out_err   = err_q;

endmodule

// File: doc/coord_to_index.md
# coord_to_index

Sequential encoder that turns a grid point (x = row, y = column) into a linear pixel index, `index = x*GRID_W + y`. It is the inverse of the index-to-coordinate decoder that feeds the triangle-area / point-in-triangle datapath. It sits upstream of the point registers, so test points and vertices can be entered as coordinates and stored as indices. The multiply uses iterative shift-add, one bit of x per clock, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `GRID_W`, default 600: row width; y must be < GRID_W.
- `GRID_H`, default 600: row count; x must be < GRID_H.
- `COORD_W`, default 11: width of x and y.
- `INDEX_W`, default 33: width of the index.

Ports (clock and reset first):
- `CLOCK_50`  in  1: single clock, rising edge.
- `RESET_N`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: x/y presented.
- `in_ready`  out  1: block idle, can accept.
- `in_x`  in  COORD_W: row.
- `in_y`  in  COORD_W: column.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer takes result.
- `out_index`  out  INDEX_W: x*GRID_W + y; 0 when out_err is set.
- `out_err`  out  1: coordinate out of range.

## Operation
States: IDLE, MUL, DONE.

- **IDLE**
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch x and y; clear acc and bit counter.
  - If x >= GRID_H or y >= GRID_W: go to DONE with err=1 and index=0.
  - Otherwise go to MUL.
- **MUL**
  - Each cycle processes bit k = cnt of x, LSB first: if x[k], acc += GRID_W << k; then cnt++.
  - After bit COORD_W-1, go to DONE with `out_index` = acc + y and err=0.
- **DONE**
  - `out_valid`=1; `out_index` and `out_err` held stable.
  - On `out_valid & out_ready`: go to IDLE.

Rules:
- `in_ready` = (state == IDLE). Inputs are ignored in all other states.
- acc is INDEX_W wide; all sums are unsigned, with no truncation for in-range inputs (max 359 999 < 2^33).
- Range check is strict (`>=`). Boundary values GRID_W-1 and GRID_H-1 are valid.
- x = 0 still runs all COORD_W MUL cycles. Latency is fixed, not data-dependent.
- `out_index`/`out_err` change only on entry to DONE; they keep their value after the handshake until the next result.
- `RESET_N` low, at any time including mid-MUL or in DONE: immediately state=IDLE, acc=0, cnt=0, `out_valid`=0, `out_index`=0, `out_err`=0. Any in-flight operation is discarded with no output.

## Timing
Reset values:
- `in_ready`=1, `out_valid`=0, `out_index`=0, `out_err`=0.

Latency:
- Valid point: accept at edge E0; `out_valid` rises after edge E0+COORD_W (11 cycles).
- Out-of-range point: `out_valid` rises after edge E0+1.

Handshake:
- `out_valid` falls on the edge where `out_ready`=1 is sampled.
- `in_ready` rises in that same cycle (state IDLE).
- Earliest next accept is one edge later.
- Best-case throughput: one result per COORD_W+2 cycles.

Backpressure and input stability:
- With `out_ready` held low, the block stays in DONE indefinitely with outputs unchanged.
- `in_valid` may stay high while busy; the pending point is accepted on the first IDLE edge.

## Structure
- Shared package: GRID_W, GRID_H, COORD_W, INDEX_W constants (also used by the decoder and area blocks) and the IDLE/MUL/DONE state enum.
- One sub-module: `mult_shift_add`
  - Holds acc, cnt and the per-bit add.
  - Interface: start/busy/done plus operands.
  - The top-level handles the FSM, range check, y add and handshakes.

## Test plan
- **Reset and simple encodes.** After reset, check `in_ready`=1, `out_valid`=0, `out_index`=0. Encode (0,0) → index 0, err 0, `out_valid` exactly 11 cycles after accept.
- **Round trip with decoder.** (5,399) → 3399 and (3,0) → 1800. Feeding each index to the decoder returns the same x,y.
- **Corners.** (599,599) → 359999, err 0. (600,0) → err 1, index 0, `out_valid` 1 cycle after accept. (0,600) → err 1.
- **Backpressure.** Hold `out_ready`=0 for 20 cycles after (2,10) → 1210. `out_index` stays stable, `in_ready` stays 0, a new `in_valid` is not accepted. Release; next point accepted the cycle after the handshake.
- **Reset mid-operation.** Drop `RESET_N` at MUL cycle 5 of (7,7). All outputs clear asynchronously. After release, (1,1) → 601 with no stale result emitted.
- **Back-to-back stream.** `in_valid` held high over 100 random in-range points, `out_ready` random. Every result equals x*600+y, in order, with none dropped or duplicated.
